data_mem_responder: RTL and testbench

//  Wait-stated data-memory responder for the MIPS CPU load/store port. It sits on the
//  CPU's Addr/WriteData/MemRead/MemWrite outputs in place of a zero-latency RAM.
//  It answers each access after a programmable number of wait cycles, using a Ready

---
 rtl/data_mem_responder_if.sv | 20 ++
 rtl/data_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// CPU load/store port bundle between the MIPS core (master) and the data-memory responder (slave).
interface data_mem_responder_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_data;
    logic        ready;
    logic        addr_err;

    modport master (
        output addr, write_data, mem_read, mem_write,
        input  read_data, ready, addr_err
    );

    modport slave (
        input  addr, write_data, mem_read, mem_write,
        output read_data, ready, addr_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-stated data-memory responder: answers CPU loads/stores after WAIT_CYCLES with a Ready pulse.
// Optional DMEM_RESET_CLEAR_EN: after reset, zero every word (one per cycle) before accepting requests.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    data_mem_responder_if.slave  io_mem
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
`ifdef DMEM_RESET_CLEAR_EN
    localparam logic [1:0] S_CLEAR = 2'd3;
    localparam logic [1:0] S_RESET = S_CLEAR;
`else
    localparam logic [1:0] S_RESET = S_IDLE;
`endif

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_word;
    logic [DW-1:0]         r_wdata;
    logic                  r_is_wr;
    logic [DW-1:0]         r_rdata;
    logic                  r_ready;
    logic                  r_addr_err;
    logic [DW-1:0]         r_mem [DEPTH];
`ifdef DMEM_RESET_CLEAR_EN
    logic [ADDR_WIDTH-1:0] r_clr_idx;
`endif

    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_req;
    logic                  w_bad_addr;
    logic                  w_held;
    logic                  w_latch;
    logic                  w_err;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [DW-1:0]         w_wdata;
    logic                  w_is_wr;

    assign w_req      = io_mem.mem_read | io_mem.mem_write;
    // Misaligned, beyond the memory depth, or an ambiguous read+write request.
    assign w_bad_addr = (io_mem.addr[1:0] != 2'b00)
                      || ((io_mem.addr >> (ADDR_WIDTH + 2)) != 32'd0)
                      || (io_mem.mem_read && io_mem.mem_write);
    assign w_held     = r_is_wr ? io_mem.mem_write : io_mem.mem_read;

    // Next-state logic; w_commit marks the edge entering DONE, where the access takes effect.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_err       = 1'b0;
        w_commit    = 1'b0;
        w_word      = r_word;
        w_wdata     = r_wdata;
        w_is_wr     = r_is_wr;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_bad_addr) begin
                        w_err = 1'b1;
                    end else begin
                        w_latch = 1'b1;
                        w_word  = io_mem.addr[ADDR_WIDTH+1:2];
                        w_wdata = io_mem.write_data;
                        w_is_wr = io_mem.mem_write;
                        if (WAIT_CYCLES == 0) begin
                            w_state_nxt = S_DONE;
                            w_commit    = 1'b1;
                        end else begin
                            w_state_nxt = S_WAIT;
                            w_cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
            end
            S_WAIT: begin
                if (!w_held) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
`ifdef DMEM_RESET_CLEAR_EN
            S_CLEAR: begin
                if (r_clr_idx == ADDR_WIDTH'(DEPTH - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_RESET;
            r_cnt      <= '0;
            r_word     <= '0;
            r_wdata    <= '0;
            r_is_wr    <= 1'b0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_addr_err <= 1'b0;
`ifdef DMEM_RESET_CLEAR_EN
            r_clr_idx  <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ready    <= w_commit;
            r_addr_err <= w_err;
            if (w_latch) begin
                r_word  <= w_word;
                r_wdata <= w_wdata;
                r_is_wr <= w_is_wr;
            end
            if (w_commit && !w_is_wr) begin
                r_rdata <= r_mem[w_word];
            end
`ifdef DMEM_RESET_CLEAR_EN
            if (r_state == S_CLEAR) begin
                r_clr_idx <= r_clr_idx + ADDR_WIDTH'(1);
            end
`endif
        end
    end

    // Storage is never reset; writes are suppressed while reset is asserted.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (w_commit && w_is_wr) begin
                r_mem[w_word] <= w_wdata;
            end
`ifdef DMEM_RESET_CLEAR_EN
            else if (r_state == S_CLEAR) begin
                r_mem[r_clr_idx] <= '0;
            end
`endif
        end
    end

    assign io_mem.read_data = r_rdata;
    assign io_mem.ready     = r_ready;
    assign io_mem.addr_err  = r_addr_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic        t_rd;
    logic        t_wr;
    logic        sel;

    always #5 clk = ~clk;

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();

    assign bus_a.addr       = t_addr;
    assign bus_a.write_data = t_wdata;
    assign bus_a.mem_read   = t_rd & ~sel;
    assign bus_a.mem_write  = t_wr & ~sel;
    assign bus_b.addr       = t_addr;
    assign bus_b.write_data = t_wdata;
    assign bus_b.mem_read   = t_rd & sel;
    assign bus_b.mem_write  = t_wr & sel;

    data_mem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(2)) u_dut_a (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_mem (bus_a.slave)
    );

    data_mem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(0)) u_dut_b (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_mem (bus_b.slave)
    );

    logic        w_ready;
    logic        w_err;
    logic [31:0] w_rdata;
    assign w_ready = sel ? bus_b.ready     : bus_a.ready;
    assign w_err   = sel ? bus_b.addr_err  : bus_a.addr_err;
    assign w_rdata = sel ? bus_b.read_data : bus_a.read_data;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hold a request until Ready/AddrErr (bounded), check latency and data, then idle one cycle.
    task automatic access(input string tag, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int exp_lat, input logic [31:0] exp_rd);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        t_addr = a; t_wdata = d; t_rd = ~wr; t_wr = wr;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (w_ready || w_err) seen = 1'b1;
        end
        check({tag, "_lat"},   32'(n), 32'(exp_lat));
        check({tag, "_err"},   32'(w_err), 32'd0);
        check({tag, "_rdata"}, w_rdata, exp_rd);
        t_rd = 1'b0; t_wr = 1'b0;
        tick();
        check({tag, "_pulse"}, 32'(w_ready), 32'd0);
        check({tag, "_hold"},  w_rdata, exp_rd);
    endtask

    // One-cycle request that must be rejected with a single AddrErr pulse.
    task automatic err_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] exp_rd);
        t_addr = a; t_wdata = 32'h0BAD_0BAD; t_rd = rd; t_wr = wr;
        tick();
        check({tag, "_err"},   32'(w_err), 32'd1);
        check({tag, "_rdy"},   32'(w_ready), 32'd0);
        check({tag, "_rdata"}, w_rdata, exp_rd);
        t_rd = 1'b0; t_wr = 1'b0;
        tick();
        check({tag, "_err_off"}, 32'(w_err), 32'd0);
        check({tag, "_rdy_off"}, 32'(w_ready), 32'd0);
        check({tag, "_hold"},    w_rdata, exp_rd);
    endtask

    task automatic after_reset;
`ifdef DMEM_RESET_CLEAR_EN
        for (int i = 0; i < 64; i++) begin
            tick();
            check("clear_rdy", 32'(w_ready), 32'd0);
        end
`endif
    endtask

    logic [31:0] exp8;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; t_addr = '0; t_wdata = '0; t_rd = 1'b0; t_wr = 1'b0; sel = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(w_ready), 32'd0);
        check("rst_err",   32'(w_err),   32'd0);
        check("rst_rdata", w_rdata,      32'd0);
        rst_n = 1'b1;
        after_reset();

        // Basic store/load with two wait cycles, including the top word.
        access("st10", 1'b1, 32'h10, 32'hDEADBEEF, 3, 32'h0);
        access("ld10", 1'b0, 32'h10, 32'h0,        3, 32'hDEADBEEF);
        access("stfc", 1'b1, 32'hFC, 32'h0F0F0F0F, 3, 32'hDEADBEEF);
        access("ldfc", 1'b0, 32'hFC, 32'h0,        3, 32'h0F0F0F0F);

        // Address errors leave ReadData alone.
        err_access("mis12",  1'b1, 1'b0, 32'h12,  32'h0F0F0F0F);
        err_access("oor100", 1'b1, 1'b0, 32'h100, 32'h0F0F0F0F);
        err_access("rdwr",   1'b1, 1'b1, 32'h10,  32'h0F0F0F0F);

        // Store aborted in the first WAIT cycle must not land.
        access("st20", 1'b1, 32'h20, 32'h11111111, 3, 32'h0F0F0F0F);
        t_addr = 32'h20; t_wdata = 32'h5; t_wr = 1'b1;
        tick();
        t_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_rdy", 32'(w_ready), 32'd0);
        end
        access("ld20", 1'b0, 32'h20, 32'h0, 3, 32'h11111111);

        // Reset during WAIT drops the store.
        access("st8", 1'b1, 32'h8, 32'h22222222, 3, 32'h11111111);
        t_addr = 32'h8; t_wdata = 32'hA5A5A5A5; t_wr = 1'b1;
        tick();
        rst_n = 1'b0; t_wr = 1'b0;
        tick();
        check("midrst_rdy",   32'(w_ready), 32'd0);
        check("midrst_rdata", w_rdata,      32'd0);
        rst_n = 1'b1;
        after_reset();
`ifdef DMEM_RESET_CLEAR_EN
        exp8 = 32'h0;
`else
        exp8 = 32'h22222222;
`endif
        access("ld8", 1'b0, 32'h8, 32'h0, 3, exp8);

        // Zero-wait instance: back-to-back accesses, two cycles apart.
        sel = 1'b1;
        access("b_st0", 1'b1, 32'h0, 32'hCAFE0000, 1, 32'h0);
        access("b_st4", 1'b1, 32'h4, 32'h0000BEEF, 1, 32'h0);
        access("b_ld0", 1'b0, 32'h0, 32'h0,        1, 32'hCAFE0000);
        access("b_ld4", 1'b0, 32'h4, 32'h0,        1, 32'h0000BEEF);
        sel = 1'b0;

`ifdef DMEM_RESET_CLEAR_EN
        access("st_c", 1'b1, 32'hC, 32'h00001234, 3, exp8);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        after_reset();
        access("ld_c", 1'b0, 32'hC, 32'h0, 3, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
